// File: rtl/genie_merge_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin merge node.
package genie_merge_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/genie_merge_arb_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, circularly.
module genie_rr_pick
    import genie_merge_pkg::*;
#(
    parameter int NI   = 2,
    parameter int SELW = sel_width(NI)
) (
    input  logic [NI-1:0]   i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic            o_any,
    output logic [SELW-1:0] o_idx
);

    logic [NI-1:0] w_rot;

    // Doubling the vector lets a plain shift rotate priority to start at i_ptr
    assign w_rot = NI'({i_req, i_req} >> i_ptr);
    assign o_any = |i_req;

    always_comb begin
        o_idx = '0;
        for (int j = NI - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_idx = SELW'((int'(i_ptr) + j) % NI);
            end
        end
    end

endmodule

// File: rtl/genie_merge_arb.sv
// Round-robin merge of NI packet streams; grant is held from first beat to eop.
module genie_merge_arb
    import genie_merge_pkg::*;
#(
    parameter int NI      = 2,
    parameter int WIDTH   = 8,
    parameter int REG_OUT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NI*WIDTH-1:0] i_data,
    input  logic [NI-1:0]       i_valid,
    output logic [NI-1:0]       o_ready,
    input  logic [NI-1:0]       i_eop,
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_data,
    input  logic                i_ready,
    output logic                o_eop
);

    localparam int SELW = sel_width(NI);

    if (NI < 2) begin : g_bad_ni
        $error("genie_merge_arb: NI must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("genie_merge_arb: WIDTH must be >= 1");
    end

    arb_state_t      r_state;
    logic [SELW-1:0] r_rr_ptr;
    logic [SELW-1:0] r_lock_idx;

    logic             w_pick_any;
    logic [SELW-1:0]  w_pick_idx;
    logic [SELW-1:0]  w_sel;
    logic             w_sel_valid;
    logic             w_sel_eop;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_acc;
    logic             w_rdy_gate;
    logic             w_up_xfer;
    logic [NI-1:0]    w_lock_oh;

    genie_rr_pick #(
        .NI   (NI),
        .SELW (SELW)
    ) u_pick (
        .i_req (i_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    assign w_sel       = (r_state == ARB_LOCKED) ? r_lock_idx : w_pick_idx;
    assign w_sel_valid = (r_state == ARB_LOCKED) ? i_valid[r_lock_idx]
                                                 : w_pick_any;
    assign w_sel_eop   = i_eop[w_sel];
    assign w_sel_data  = i_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_up_xfer   = w_sel_valid & w_acc;
    assign w_lock_oh   = NI'(1) << r_lock_idx;

    for (genvar k = 0; k < NI; k++) begin : g_rdy
        assign o_ready[k] = w_acc & w_rdy_gate & (w_sel == SELW'(k));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else if (w_up_xfer) begin
            if (w_sel_eop) begin
                r_state  <= ARB_IDLE;
                r_rr_ptr <= (w_sel == SELW'(NI - 1)) ? '0
                                                     : w_sel + SELW'(1);
            end else begin
                r_state    <= ARB_LOCKED;
                r_lock_idx <= w_sel;
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic             r_full;
        logic [WIDTH-1:0] r_data;
        logic             r_eop;

        // A draining buffer can take a new beat in the same cycle
        assign w_acc      = ~r_full | i_ready;
        assign w_rdy_gate = 1'b1;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_full <= 1'b0;
                r_data <= '0;
                r_eop  <= 1'b0;
            end else if (w_up_xfer) begin
                r_full <= 1'b1;
                r_data <= w_sel_data;
                r_eop  <= w_sel_eop;
            end else if (r_full & i_ready) begin
                r_full <= 1'b0;
            end
        end

        assign o_valid = r_full;
        assign o_data  = r_data;
        assign o_eop   = r_eop;
    end else begin : g_comb
        assign w_acc      = i_ready;
        assign w_rdy_gate = w_sel_valid;
        assign o_valid    = w_sel_valid;
        assign o_data     = w_sel_data;
        assign o_eop      = w_sel_eop;
    end

    always @(posedge clk) begin
        if (!reset && r_state == ARB_LOCKED) begin
            assert ((i_valid & o_ready & ~w_lock_oh) == '0);
        end
    end

endmodule
